// File: rtl/mmio_fifo_pkg.sv
// Shared constants and status layout for the MMIO write FIFO and the AFU read mux.
// The status struct is what software sees when it reads the STATUS CSR.
package mmio_fifo_pkg;

    localparam int FIFO_WIDTH = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [15:0] CSR_DATA   = 16'h0020;
    localparam logic [15:0] CSR_STATUS = 16'h0022;
    localparam logic [15:0] CSR_CTRL   = 16'h0024;

    typedef struct packed {
        logic                  overflow;
        logic                  underflow;
        logic                  full;
        logic                  empty;
        logic [FIFO_CNT_W-1:0] count;
    } t_fifo_status;

endpackage

// File: rtl/mmio_fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; occupancy logic decides what is valid.
module mmio_fifo_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_wr_fifo.sv
// Circular-buffer FIFO between MMIO data-CSR writes (push) and data-CSR reads (pop).
// Pointers wrap by compare so any DEPTH >= 2 works; error flags are sticky until clr_err.
module mmio_wr_fifo
    import mmio_fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] ram_rdata;
    logic             push_acc, pop_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    mmio_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
    assign pop_acc  = rd_en && !empty;
    assign push_acc = wr_en && (!full || pop_acc);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = pop_acc;
        overflow_d  = clr_err ? 1'b0 : overflow_q;
        underflow_d = clr_err ? 1'b0 : underflow_q;

        if (push_acc) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_acc) begin
            rd_ptr_d  = ptr_inc(rd_ptr_q);
            rd_data_d = ram_rdata;
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + CW'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CW'(1);
        end

        // A new error in the same cycle as clr_err must stay visible.
        if (wr_en && !push_acc) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign head      = empty ? '0 : ram_rdata;
    assign count     = count_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_mmio_wr_fifo.sv
// Directed table for an 8-deep FIFO plus a random queue-model run on a 5-deep instance.
module tb_mmio_wr_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        wr_en, rd_en, clr_err;
    logic [63:0] wr_data;
    logic [63:0] rd_data, head;
    logic        rd_valid, full, empty, overflow, underflow;
    logic [3:0]  count;

    logic        wr5, rd5, clr5;
    logic [63:0] wd5;
    logic [63:0] rd_data5, head5;
    logic        rd_valid5, full5, empty5, overflow5, underflow5;
    logic [2:0]  count5;

    mmio_wr_fifo #(.WIDTH(64), .DEPTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .head(head), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    mmio_wr_fifo #(.WIDTH(64), .DEPTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr5), .wr_data(wd5), .rd_en(rd5),
        .rd_data(rd_data5), .rd_valid(rd_valid5), .head(head5), .full(full5), .empty(empty5),
        .count(count5), .overflow(overflow5), .underflow(underflow5), .clr_err(clr5)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [63:0] wd;
        logic        rd;
        logic        clr;
        logic [3:0]  cnt;
        logic        vld;
        logic [63:0] rdat;
        logic [63:0] hd;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [63:0] wd, input logic rd,
                                input logic clr, input int cnt, input logic vld,
                                input logic [63:0] rdat, input logic [63:0] hd,
                                input logic ovf, input logic unf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.clr = clr; v.cnt = 4'(cnt);
        v.vld = vld; v.rdat = rdat; v.hd = hd; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endfunction

    logic [63:0] q[$];
    logic        m_ovf, m_unf, pop_acc, push_acc, exp_vld;
    logic [63:0] exp_rd, exp_hd;

    initial begin
        rst_n = 1'b0;
        wr_en = 0; rd_en = 0; clr_err = 0; wr_data = '0;
        wr5 = 0; rd5 = 0; clr5 = 0; wd5 = '0;

        // Sequence of pops after the mid-run reset: 3 pushes, 3 pops
        add(1, 64'h11, 0, 0, 1, 0, 64'h0, 64'h11, 0, 0);
        add(1, 64'h22, 0, 0, 2, 0, 64'h0, 64'h11, 0, 0);
        add(1, 64'h33, 0, 0, 3, 0, 64'h0, 64'h11, 0, 0);
        add(0, 64'h0, 1, 0, 2, 1, 64'h11, 64'h22, 0, 0);
        add(0, 64'h0, 1, 0, 1, 1, 64'h22, 64'h33, 0, 0);
        add(0, 64'h0, 1, 0, 0, 1, 64'h33, 64'h0, 0, 0);
        add(0, 64'h0, 0, 0, 0, 0, 64'h33, 64'h0, 0, 0);
        // Fill, dropped 9th push, drain
        for (int i = 0; i < 8; i++) add(1, 64'h100 + 64'(i), 0, 0, i + 1, 0, 64'h33, 64'h100, 0, 0);
        add(1, 64'hDEAD, 0, 0, 8, 0, 64'h33, 64'h100, 1, 0);
        for (int j = 0; j < 8; j++)
            add(0, 64'h0, 1, 0, 7 - j, 1, 64'h100 + 64'(j), (j < 7) ? 64'h101 + 64'(j) : 64'h0, 1, 0);
        add(0, 64'h0, 0, 1, 0, 0, 64'h107, 64'h0, 0, 0);
        // Full with simultaneous push+pop, then drain through the wrapped entry
        for (int i = 0; i < 8; i++) add(1, 64'h100 + 64'(i), 0, 0, i + 1, 0, 64'h107, 64'h100, 0, 0);
        add(1, 64'h200, 1, 0, 8, 1, 64'h100, 64'h101, 0, 0);
        for (int j = 0; j < 8; j++)
            add(0, 64'h0, 1, 0, 7 - j, 1, (j < 7) ? 64'h101 + 64'(j) : 64'h200,
                (j < 6) ? 64'h102 + 64'(j) : ((j == 6) ? 64'h200 : 64'h0), 0, 0);
        // Empty with simultaneous push+pop: no bypass, underflow set
        add(1, 64'h55, 1, 0, 1, 0, 64'h200, 64'h55, 0, 1);
        add(0, 64'h0, 0, 1, 1, 0, 64'h200, 64'h55, 0, 0);
        add(0, 64'h0, 1, 0, 0, 1, 64'h55, 64'h0, 0, 0);
        // Underflow in the same cycle as clr_err wins, then a plain clear
        add(0, 64'h0, 1, 1, 0, 0, 64'h55, 64'h0, 0, 1);
        add(0, 64'h0, 0, 1, 0, 0, 64'h55, 64'h0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_full", 64'(full), 64'd0);
        check("reset_rd_valid", 64'(rd_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_count", 64'(count), 64'd0);
        check("idle_empty", 64'(empty), 64'd1);
        check("idle_full", 64'(full), 64'd0);
        check("idle_head", head, 64'd0);
        check("idle_rd_valid", 64'(rd_valid), 64'd0);
        check("idle_rd_data", rd_data, 64'd0);
        check("idle_flags", {62'd0, overflow, underflow}, 64'd0);

        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_data = 64'hA0 + 64'(i);
            @(posedge clk);
            #1;
        end
        wr_en = 0;
        check("midrun_count_pre", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_async_count", 64'(count), 64'd0);
        check("midrun_async_empty", 64'(empty), 64'd1);
        check("midrun_async_head", head, 64'd0);
        $display("mid-run reset: count=%0d empty=%b head=%h", count, empty, head);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            wr_en = vecs[i].wr; wr_data = vecs[i].wd; rd_en = vecs[i].rd; clr_err = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].cnt == 4'd8));
            check($sformatf("vec%0d_empty", i), 64'(empty), 64'(vecs[i].cnt == 4'd0));
            check($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vecs[i].vld));
            check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rdat);
            check($sformatf("vec%0d_head", i), head, vecs[i].hd);
            check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
            check($sformatf("vec%0d_underflow", i), 64'(underflow), 64'(vecs[i].unf));
            $display("vec %0d: wr=%b wd=%h rd=%b clr=%b -> count=%0d rd_valid=%b rd_data=%h head=%h ovf=%b unf=%b",
                     i, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr, count, rd_valid, rd_data,
                     head, overflow, underflow);
        end
        wr_en = 0; rd_en = 0; clr_err = 0;

        // Random traffic on the 5-deep instance, which has been idle since reset
        m_ovf = 0; m_unf = 0;
        for (int c = 0; c < 10000; c++) begin
            wr5  = 1'($urandom_range(0, 1));
            rd5  = 1'($urandom_range(0, 1));
            clr5 = ($urandom_range(0, 31) == 0);
            wd5  = {$urandom, $urandom};
            pop_acc  = rd5 && (q.size() > 0);
            push_acc = wr5 && ((q.size() < 5) || pop_acc);
            exp_vld  = pop_acc;
            if (pop_acc) exp_rd = q.pop_front();
            if (push_acc) q.push_back(wd5);
            if (clr5) begin
                m_ovf = 0; m_unf = 0;
            end
            if (wr5 && !push_acc) m_ovf = 1;
            if (rd5 && !pop_acc) m_unf = 1;
            exp_hd = (q.size() > 0) ? q[0] : 64'h0;
            @(posedge clk);
            #1;
            check("rand_count", 64'(count5), 64'(q.size()));
            check("rand_full", 64'(full5), 64'(q.size() == 5));
            check("rand_empty", 64'(empty5), 64'(q.size() == 0));
            check("rand_rd_valid", 64'(rd_valid5), 64'(exp_vld));
            if (exp_vld) check("rand_rd_data", rd_data5, exp_rd);
            check("rand_head", head5, exp_hd);
            check("rand_overflow", 64'(overflow5), 64'(m_ovf));
            check("rand_underflow", 64'(underflow5), 64'(m_unf));
        end
        wr5 = 0; rd5 = 0; clr5 = 0;
        $display("random run: 10000 cycles on depth-5 instance, final count=%0d", count5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
